// File: rtl/wash_sequencer.sv
// wash_sequencer
// Steps the laundry program (fill, wash, drain, rinse, spin) and drives the
// water valve, drain pump and motor. The program only advances while the
// top-level controller grants `run`. The total time left is reported for the
// display, and `hadFinish` is raised when the program completes.
//
// Ports:
//   cp        system clock, all state changes on the rising edge
//   reset     asynchronous active-high reset to IDLE with all outputs off
//   run       high while the top-level controller is running, low = paused
//   tick      one-cycle 1 Hz time-base enable
//   clr       synchronous abort / acknowledge, returns to IDLE
//   mode      program select: 0 full, 1 wash+spin, 2 rinse+spin, 3 spin only
//   phase     current phase code (IDLE=0 .. DONE=8)
//   remain    ticks remaining in the whole program
//   waterIn   water inlet valve
//   drain     drain pump
//   motor     00 off, 01 slow agitate, 10 fast spin
//   hadFinish program complete flag
module wash_sequencer #(
    parameter int FILL_T  = 3,
    parameter int WASH_T  = 10,
    parameter int DRAIN_T = 3,
    parameter int RINSE_T = 5,
    parameter int SPIN_T  = 6
) (
    input  logic       cp,
    input  logic       reset,
    input  logic       run,
    input  logic       tick,
    input  logic       clr,
    input  logic [1:0] mode,
    output logic [3:0] phase,
    output logic [7:0] remain,
    output logic       waterIn,
    output logic       drain,
    output logic [1:0] motor,
    output logic       hadFinish
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FILL   = 4'd1,
        WASH   = 4'd2,
        DRAIN  = 4'd3,
        RFILL  = 4'd4,
        RINSE  = 4'd5,
        RDRAIN = 4'd6,
        SPIN   = 4'd7,
        DONE   = 4'd8
    } phase_t;

    phase_t     phase_q, phase_d;
    phase_t     adv_phase;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] remain_q, remain_d;
    logic [1:0] mode_q, mode_d;
    logic       water_q, water_d;
    logic       drain_q, drain_d;
    logic [1:0] motor_q, motor_d;
    logic       fin_q, fin_d;

    // Duration of a phase in ticks; the rinse fill and rinse drain reuse the
    // fill and drain timings.
    function automatic logic [7:0] dur_of(input phase_t p);
        case (p)
            FILL, RFILL:   dur_of = 8'(FILL_T);
            WASH:          dur_of = 8'(WASH_T);
            DRAIN, RDRAIN: dur_of = 8'(DRAIN_T);
            RINSE:         dur_of = 8'(RINSE_T);
            SPIN:          dur_of = 8'(SPIN_T);
            default:       dur_of = 8'd0;
        endcase
    endfunction

    function automatic phase_t first_of(input logic [1:0] m);
        case (m)
            2'd0, 2'd1: first_of = FILL;
            2'd2:       first_of = RFILL;
            default:    first_of = SPIN;
        endcase
    endfunction

    function automatic logic [7:0] total_of(input logic [1:0] m);
        case (m)
            2'd0:    total_of = 8'(2 * FILL_T + WASH_T + 2 * DRAIN_T + RINSE_T + SPIN_T);
            2'd1:    total_of = 8'(FILL_T + WASH_T + DRAIN_T + SPIN_T);
            2'd2:    total_of = 8'(FILL_T + RINSE_T + DRAIN_T + SPIN_T);
            default: total_of = 8'(SPIN_T);
        endcase
    endfunction

    // The full program is the only one that branches from the first drain
    // into the rinse cycle; wash+spin jumps straight to spin.
    function automatic phase_t next_of(input phase_t p, input logic [1:0] m);
        case (p)
            FILL:    next_of = WASH;
            WASH:    next_of = DRAIN;
            DRAIN:   next_of = (m == 2'd0) ? RFILL : SPIN;
            RFILL:   next_of = RINSE;
            RINSE:   next_of = RDRAIN;
            RDRAIN:  next_of = SPIN;
            SPIN:    next_of = DONE;
            default: next_of = p;
        endcase
    endfunction

    assign adv_phase = next_of(phase_q, mode_q);

    // Next-state logic: clr wins over everything, a start from IDLE loads the
    // whole program at once, and running phases count down on each tick.
    // Actuators are derived from the next phase so they change on the same
    // edge as the phase code, and they drop whenever run is low.
    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        remain_d = remain_q;
        mode_d   = mode_q;
        if (clr) begin
            phase_d  = IDLE;
            cnt_d    = 8'd0;
            remain_d = 8'd0;
            mode_d   = 2'd0;
        end else begin
            case (phase_q)
                IDLE: begin
                    if (run) begin
                        mode_d   = mode;
                        phase_d  = first_of(mode);
                        cnt_d    = dur_of(first_of(mode));
                        remain_d = total_of(mode);
                    end
                end
                DONE: begin
                    remain_d = 8'd0;
                end
                default: begin
                    if (run && tick) begin
                        if (remain_q != 8'd0) begin
                            remain_d = remain_q - 8'd1;
                        end
                        if (cnt_q > 8'd1) begin
                            cnt_d = cnt_q - 8'd1;
                        end else begin
                            phase_d = adv_phase;
                            cnt_d   = dur_of(adv_phase);
                        end
                    end
                end
            endcase
        end

        water_d = run && !clr && (phase_d == FILL || phase_d == RFILL);
        drain_d = run && !clr && (phase_d == DRAIN || phase_d == RDRAIN || phase_d == SPIN);
        motor_d = 2'b00;
        if (run && !clr) begin
            if (phase_d == WASH || phase_d == RINSE) begin
                motor_d = 2'b01;
            end else if (phase_d == SPIN) begin
                motor_d = 2'b10;
            end
        end
        fin_d = (phase_d == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge cp or posedge reset) begin
        if (reset) begin
            phase_q  <= IDLE;
            cnt_q    <= 8'd0;
            remain_q <= 8'd0;
            mode_q   <= 2'd0;
            water_q  <= 1'b0;
            drain_q  <= 1'b0;
            motor_q  <= 2'b00;
            fin_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            remain_q <= remain_d;
            mode_q   <= mode_d;
            water_q  <= water_d;
            drain_q  <= drain_d;
            motor_q  <= motor_d;
            fin_q    <= fin_d;
        end
    end

    assign phase     = phase_q;
    assign remain    = remain_q;
    assign waterIn   = water_q;
    assign drain     = drain_q;
    assign motor     = motor_q;
    assign hadFinish = fin_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer
// Self-checking bench for wash_sequencer. Each program start pushes the
// expected phase/remain trace (built from the phase durations) into a
// scoreboard queue; every tick edge pops one entry and compares it together
// with the actuator levels expected for that phase.
module tb_wash_sequencer;

    localparam int FILL_T  = 3;
    localparam int WASH_T  = 10;
    localparam int DRAIN_T = 3;
    localparam int RINSE_T = 5;
    localparam int SPIN_T  = 6;

    logic       cp = 1'b0;
    logic       reset;
    logic       run;
    logic       tick;
    logic       clr;
    logic [1:0] mode;
    logic [3:0] phase;
    logic [7:0] remain;
    logic       waterIn;
    logic       drain;
    logic [1:0] motor;
    logic       hadFinish;
    logic [16:0] obs;

    typedef struct {
        logic [3:0] ph;
        logic [7:0] rem;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    wash_sequencer #(
        .FILL_T (FILL_T),
        .WASH_T (WASH_T),
        .DRAIN_T(DRAIN_T),
        .RINSE_T(RINSE_T),
        .SPIN_T (SPIN_T)
    ) dut (
        .cp       (cp),
        .reset    (reset),
        .run      (run),
        .tick     (tick),
        .clr      (clr),
        .mode     (mode),
        .phase    (phase),
        .remain   (remain),
        .waterIn  (waterIn),
        .drain    (drain),
        .motor    (motor),
        .hadFinish(hadFinish)
    );

    always #5 cp = ~cp;

    assign obs = {phase, remain, waterIn, drain, motor, hadFinish};

    // Expected observable vector for a phase, remaining count and run level.
    function automatic logic [16:0] exp_vec(input logic [3:0] p, input logic [7:0] r, input logic rn);
        logic       w;
        logic       d;
        logic [1:0] m;
        w = rn && (p == 4'd1 || p == 4'd4);
        d = rn && (p == 4'd3 || p == 4'd6 || p == 4'd7);
        m = 2'b00;
        if (rn && (p == 4'd2 || p == 4'd5)) m = 2'b01;
        if (rn && p == 4'd7) m = 2'b10;
        return {p, r, w, d, m, (p == 4'd8)};
    endfunction

    function automatic int dur_of(input int p);
        case (p)
            1, 4:    return FILL_T;
            2:       return WASH_T;
            3, 6:    return DRAIN_T;
            5:       return RINSE_T;
            7:       return SPIN_T;
            default: return 0;
        endcase
    endfunction

    // Builds the expected trace: the start entry, one entry per tick and
    // the final DONE entry.
    task automatic push_program(input logic [1:0] m);
        int  prog[$];
        int  total;
        sb_t e;
        case (m)
            2'd0:    prog = '{1, 2, 3, 4, 5, 6, 7};
            2'd1:    prog = '{1, 2, 3, 7};
            2'd2:    prog = '{4, 5, 6, 7};
            default: prog = '{7};
        endcase
        total = 0;
        foreach (prog[i]) total += dur_of(prog[i]);
        foreach (prog[i]) begin
            for (int k = 0; k < dur_of(prog[i]); k++) begin
                e.ph  = 4'(prog[i]);
                e.rem = 8'(total);
                sb.push_back(e);
                total--;
            end
        end
        e.ph  = 4'd8;
        e.rem = 8'd0;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge cp);
        #1;
    endtask

    task automatic score(input string name);
        sb_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL %s: scoreboard empty, got %h", name, obs);
        end else begin
            e = sb.pop_front();
            if (obs !== exp_vec(e.ph, e.rem, run)) begin
                n_fail++;
                $display("[TB] FAIL %s: got %h expected %h (phase %0d remain %0d)",
                         name, obs, exp_vec(e.ph, e.rem, run), e.ph, e.rem);
            end
        end
    endtask

    task automatic start_program(input logic [1:0] m, input string name);
        push_program(m);
        mode = m;
        run  = 1'b1;
        step();
        score(name);
    endtask

    task automatic tick_and_score(input string name);
        repeat (3) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        score(name);
    endtask

    task automatic abort_to_idle();
        run = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run   = 1'b0;
        tick  = 1'b0;
        clr   = 1'b0;
        mode  = 2'd0;
        repeat (2) step();
        n_checks++;
        if (obs !== 17'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_hold: got %h expected %h", obs, 17'd0);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (obs !== 17'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_release: got %h expected %h", obs, 17'd0);
        end
    endtask

    task automatic test_full_program();
        start_program(2'd0, "full_start");
        repeat (33) tick_and_score("full_tick");
    endtask

    task automatic test_done_hold();
        for (int i = 0; i < 8; i++) begin
            run  = i[0];
            tick = (i % 3 == 0);
            step();
            n_checks++;
            if (obs !== exp_vec(4'd8, 8'd0, run)) begin
                n_fail++;
                $display("[TB] FAIL done_hold: got %h expected %h", obs, exp_vec(4'd8, 8'd0, run));
            end
        end
        tick = 1'b0;
        abort_to_idle();
        n_checks++;
        if (obs !== 17'd0) begin
            n_fail++;
            $display("[TB] FAIL done_clr: got %h expected %h", obs, 17'd0);
        end
    endtask

    task automatic test_pause();
        start_program(2'd3, "pause_start");
        repeat (3) tick_and_score("pause_pre");
        run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick = (i % 4 == 3);
            step();
            tick = 1'b0;
            n_checks++;
            if (obs !== exp_vec(4'd7, 8'd3, 1'b0)) begin
                n_fail++;
                $display("[TB] FAIL pause_frozen: got %h expected %h", obs, exp_vec(4'd7, 8'd3, 1'b0));
            end
        end
        run = 1'b1;
        step();
        n_checks++;
        if (obs !== exp_vec(4'd7, 8'd3, 1'b1)) begin
            n_fail++;
            $display("[TB] FAIL pause_resume: got %h expected %h", obs, exp_vec(4'd7, 8'd3, 1'b1));
        end
        repeat (3) tick_and_score("pause_post");
        abort_to_idle();
    endtask

    task automatic test_mode_change();
        start_program(2'd1, "modechg_start");
        repeat (3) tick_and_score("modechg_fill");
        mode = 2'd2;
        tick_and_score("modechg_wash");
        mode = 2'd3;
        repeat (18) tick_and_score("modechg_rest");
        abort_to_idle();
        n_checks++;
        if (obs !== 17'd0) begin
            n_fail++;
            $display("[TB] FAIL modechg_idle: got %h expected %h", obs, 17'd0);
        end
    endtask

    task automatic test_clr_rinse();
        start_program(2'd2, "clr_start");
        repeat (4) tick_and_score("clr_pre");
        clr  = 1'b1;
        tick = 1'b1;
        step();
        clr  = 1'b0;
        tick = 1'b0;
        n_checks++;
        if (obs !== 17'd0) begin
            n_fail++;
            $display("[TB] FAIL clr_rinse: got %h expected %h", obs, 17'd0);
        end
        sb.delete();
        start_program(2'd3, "clr_restart");
        repeat (6) tick_and_score("clr_restart_tick");
        abort_to_idle();
    endtask

    task automatic test_async_reset();
        start_program(2'd0, "areset_start");
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== 17'd0) begin
            n_fail++;
            $display("[TB] FAIL areset_immediate: got %h expected %h", obs, 17'd0);
        end
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (obs !== 17'd0) begin
                n_fail++;
                $display("[TB] FAIL areset_hold: got %h expected %h", obs, 17'd0);
            end
        end
        run   = 1'b0;
        reset = 1'b0;
        repeat (2) step();
        n_checks++;
        if (obs !== 17'd0) begin
            n_fail++;
            $display("[TB] FAIL areset_no_resume: got %h expected %h", obs, 17'd0);
        end
    endtask

    initial begin
        test_reset();
        test_full_program();
        test_done_hold();
        test_pause();
        test_mode_change();
        test_clr_rinse();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
